axi_slave_mem: RTL and testbench

//  AXI4 memory slave at the far end of axi_master: accepts write/read bursts on all five channels, stores

---
 rtl/axi_slave_mem.sv | 261 ++++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem.sv
// AXI4 memory slave: independent write (AW/W/B) and read (AR/R) burst engines over a register-array RAM.
// One write and one read burst may be outstanding at a time; illegal bursts or beats answer SLVERR.
module axi_slave_mem #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 8,
    parameter int SIZE_BITS = 3,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                   aclk,
    input  logic                   areset_n,
    input  logic [ADDR_BITS-1:0]   aw_addr,
    input  logic [LEN_BITS-1:0]    aw_len,
    input  logic [SIZE_BITS-1:0]   aw_size,
    input  logic [1:0]             aw_burst,
    input  logic [3:0]             aw_cache,
    input  logic                   aw_valid,
    output logic                   aw_ready,
    input  logic [DATA_BITS-1:0]   w_data,
    input  logic [DATA_BITS/8-1:0] w_strb,
    input  logic                   w_last,
    input  logic                   w_valid,
    output logic                   w_ready,
    output logic [1:0]             b_resp,
    output logic                   b_valid,
    input  logic                   b_ready,
    input  logic [ADDR_BITS-1:0]   ar_addr,
    input  logic [LEN_BITS-1:0]    ar_len,
    input  logic [SIZE_BITS-1:0]   ar_size,
    input  logic [1:0]             ar_burst,
    input  logic [3:0]             ar_cache,
    input  logic                   ar_valid,
    output logic                   ar_ready,
    output logic [DATA_BITS-1:0]   r_data,
    output logic [1:0]             r_resp,
    output logic                   r_last,
    output logic                   r_valid,
    input  logic                   r_ready
);
    localparam int NBYTES   = DATA_BITS / 8;
    localparam int ADDR_LSB = $clog2(NBYTES);
    localparam int IDX_BITS = $clog2(MEM_DEPTH);

    typedef logic [ADDR_BITS-1:0] addr_t;
    typedef logic [LEN_BITS-1:0]  len_t;
    typedef logic [SIZE_BITS-1:0] size_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

    logic [DATA_BITS-1:0] mem [MEM_DEPTH];

    logic unused_cache;
    assign unused_cache = ^{aw_cache, ar_cache};

    function automatic addr_t next_addr(input addr_t addr, input size_t size,
                                        input logic [1:0] burst, input len_t len);
        addr_t step, aligned, incr, wrap_mask;
        step      = addr_t'(1) << size;
        aligned   = addr & ~(step - addr_t'(1));
        incr      = aligned + step;
        wrap_mask = ((addr_t'(len) + addr_t'(1)) << size) - addr_t'(1);
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
            default: next_addr = incr;
        endcase
    endfunction

    function automatic logic burst_err(input size_t size, input logic [1:0] burst, input len_t len);
        logic wrap_ok;
        wrap_ok = (len == len_t'(1)) || (len == len_t'(3)) || (len == len_t'(7)) || (len == len_t'(15));
        burst_err = (size > size_t'(ADDR_LSB)) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_ok);
    endfunction

    function automatic logic addr_oob(input addr_t addr);
        addr_oob = (addr >> ADDR_LSB) >= addr_t'(MEM_DEPTH);
    endfunction

    function automatic logic [IDX_BITS-1:0] word_idx(input addr_t addr);
        word_idx = IDX_BITS'(addr >> ADDR_LSB);
    endfunction

    // Holds the IDLE-state ready outputs low during and for the edge of reset.
    logic rst_done_q;

    wstate_e wstate_q, wstate_d;
    addr_t   waddr_q, waddr_d;
    len_t    wlen_q, wlen_d, wcnt_q, wcnt_d;
    size_t   wsize_q, wsize_d;
    logic [1:0] wburst_q, wburst_d;
    logic    werr_q, werr_d;
    logic    mem_we;

    always_comb begin
        wstate_d = wstate_q;
        waddr_d  = waddr_q;
        wlen_d   = wlen_q;
        wsize_d  = wsize_q;
        wburst_d = wburst_q;
        wcnt_d   = wcnt_q;
        werr_d   = werr_q;
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        b_resp   = 2'b00;
        mem_we   = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                aw_ready = rst_done_q;
                if (aw_valid && rst_done_q) begin
                    waddr_d  = aw_addr;
                    wlen_d   = aw_len;
                    wsize_d  = aw_size;
                    wburst_d = aw_burst;
                    wcnt_d   = '0;
                    werr_d   = burst_err(aw_size, aw_burst, aw_len);
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    mem_we  = !addr_oob(waddr_q) && areset_n;
                    if (addr_oob(waddr_q) || (w_last != (wcnt_q == wlen_q)))
                        werr_d = 1'b1;
                    waddr_d = next_addr(waddr_q, wsize_q, wburst_q, wlen_q);
                    wcnt_d  = wcnt_q + len_t'(1);
                    if (wcnt_q == wlen_q)
                        wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                b_valid = 1'b1;
                b_resp  = werr_q ? 2'b10 : 2'b00;
                if (b_ready)
                    wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            wstate_q   <= W_IDLE;
            werr_q     <= 1'b0;
            wcnt_q     <= '0;
            rst_done_q <= 1'b0;
        end else begin
            wstate_q   <= wstate_d;
            werr_q     <= werr_d;
            wcnt_q     <= wcnt_d;
            rst_done_q <= 1'b1;
        end
        waddr_q  <= waddr_d;
        wlen_q   <= wlen_d;
        wsize_q  <= wsize_d;
        wburst_q <= wburst_d;
    end

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (w_strb[b])
                    mem[word_idx(waddr_q)][b*8 +: 8] <= w_data[b*8 +: 8];
            end
        end
    end

    rstate_e rstate_q, rstate_d;
    addr_t   raddr_q, raddr_d, rd_addr;
    len_t    rlen_q, rlen_d, rcnt_q, rcnt_d;
    size_t   rsize_q, rsize_d;
    logic [1:0] rburst_q, rburst_d;
    logic    rberr_q, rberr_d, rd_berr, rd_load;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic [1:0] rresp_q, rresp_d;
    logic    rlast_q, rlast_d;

    always_comb begin
        rstate_d = rstate_q;
        raddr_d  = raddr_q;
        rlen_d   = rlen_q;
        rsize_d  = rsize_q;
        rburst_d = rburst_q;
        rcnt_d   = rcnt_q;
        rberr_d  = rberr_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;
        rd_addr  = raddr_q;
        rd_berr  = rberr_q;
        rd_load  = 1'b0;
        ar_ready = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                ar_ready = rst_done_q;
                if (ar_valid && rst_done_q) begin
                    rlen_d   = ar_len;
                    rsize_d  = ar_size;
                    rburst_d = ar_burst;
                    rberr_d  = burst_err(ar_size, ar_burst, ar_len);
                    rd_berr  = rberr_d;
                    rd_addr  = ar_addr;
                    rd_load  = 1'b1;
                    raddr_d  = next_addr(ar_addr, ar_size, ar_burst, ar_len);
                    rcnt_d   = '0;
                    rlast_d  = (ar_len == '0);
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_ready) begin
                    if (rcnt_q == rlen_q) begin
                        rlast_d  = 1'b0;
                        rstate_d = R_IDLE;
                    end else begin
                        rd_load = 1'b1;
                        raddr_d = next_addr(raddr_q, rsize_q, rburst_q, rlen_q);
                        rcnt_d  = rcnt_q + len_t'(1);
                        rlast_d = ((rcnt_q + len_t'(1)) == rlen_q);
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
        // Data is taken from the array before this edge's write lands, so reads see pre-write contents.
        if (rd_load) begin
            rdata_d = addr_oob(rd_addr) ? '0 : mem[word_idx(rd_addr)];
            rresp_d = (rd_berr || addr_oob(rd_addr)) ? 2'b10 : 2'b00;
        end
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            rstate_q <= R_IDLE;
            rcnt_q   <= '0;
            rberr_q  <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= 2'b00;
            rlast_q  <= 1'b0;
        end else begin
            rstate_q <= rstate_d;
            rcnt_q   <= rcnt_d;
            rberr_q  <= rberr_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
        end
        raddr_q  <= raddr_d;
        rlen_q   <= rlen_d;
        rsize_q  <= rsize_d;
        rburst_q <= rburst_d;
    end

    assign r_valid = (rstate_q == R_DATA);
    assign r_data  = rdata_q;
    assign r_resp  = rresp_q;
    assign r_last  = rlast_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: bursts, stalls, WRAP, narrow, out-of-range, error and reset cases.
module tb_axi_slave_mem;
    logic        aclk = 1'b0;
    logic        areset_n;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic [3:0]  aw_cache;
    logic        aw_valid, aw_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last, w_valid, w_ready;
    logic [1:0]  b_resp;
    logic        b_valid, b_ready;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic [3:0]  ar_cache;
    logic        ar_valid, ar_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last, r_valid, r_ready;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] wr_data [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    int          rd_n;
    int          unstable_n;
    logic [1:0]  got_bresp;

    always #5 aclk = ~aclk;

    axi_slave_mem dut (
        .aclk(aclk), .areset_n(areset_n),
        .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .aw_cache(aw_cache), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
        .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .ar_cache(ar_cache), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid), .r_ready(r_ready)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // flip_beat: beat whose w_last is inverted (-1 = none)
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] strb, input int flip_beat);
        int t;
        bit to;
        to = 0;
        aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_valid = 1'b1;
        t = 0;
        while (!aw_ready && t < 50) begin tick(); t++; end
        if (t >= 50) to = 1;
        tick();
        aw_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            w_data = wr_data[i]; w_strb = strb;
            w_last = (i == int'(len)) != (i == flip_beat);
            w_valid = 1'b1;
            t = 0;
            while (!w_ready && t < 50) begin tick(); t++; end
            if (t >= 50) to = 1;
            tick();
        end
        w_valid = 1'b0; w_last = 1'b0;
        t = 0;
        while (!b_valid && t < 50) begin tick(); t++; end
        if (t >= 50) to = 1;
        got_bresp = b_resp;
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        n_cmp++;
        if (to) begin n_fail++; $display("FAIL write_timeout addr=%h got=timeout exp=handshakes", addr); end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input bit toggle);
        int t, cyc;
        logic [34:0] prev;
        bit have_prev;
        ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_valid = 1'b1;
        t = 0;
        while (!ar_ready && t < 50) begin tick(); t++; end
        tick();
        ar_valid = 1'b0;
        rd_n = 0; unstable_n = 0; have_prev = 0; cyc = 0; prev = '0;
        while (rd_n <= int'(len) && cyc < 200) begin
            r_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (r_valid) begin
                if (have_prev && {r_data, r_resp, r_last} !== prev) unstable_n++;
                if (r_ready) begin
                    if (rd_n < 16) begin
                        rd_data[rd_n] = r_data; rd_resp[rd_n] = r_resp; rd_last[rd_n] = r_last;
                    end
                    rd_n++;
                    have_prev = 0;
                end else begin
                    prev = {r_data, r_resp, r_last};
                    have_prev = 1;
                end
            end
            tick();
            cyc++;
        end
        r_ready = 1'b0;
        n_cmp++;
        if (t >= 50 || cyc >= 200) begin
            n_fail++; $display("FAIL read_timeout addr=%h got_beats=%0d exp=%0d", addr, rd_n, int'(len) + 1);
        end
    endtask

    task automatic test_reset();
        areset_n = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp, r_last} !== 42'd0) begin
            n_fail++; $display("FAIL reset_outputs got=%h exp=0",
                {aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp, r_last});
        end
        areset_n = 1'b1;
        tick();
        n_cmp++;
        if ({aw_ready, ar_ready} !== 2'b11) begin
            n_fail++; $display("FAIL reset_ready got=%b exp=11", {aw_ready, ar_ready});
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) wr_data[i] = 32'hD000_0000 + 32'(i);
        do_write(32'h10, 8'd3, 3'd2, 2'b01, 4'hF, -1);
        n_cmp++;
        if (got_bresp !== 2'b00) begin n_fail++; $display("FAIL basic_bresp got=%b exp=00", got_bresp); end
        do_read(32'h10, 8'd3, 3'd2, 2'b01, 1'b0);
        n_cmp++;
        if (rd_n !== 4) begin n_fail++; $display("FAIL basic_beats got=%0d exp=4", rd_n); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({rd_data[i], rd_resp[i], rd_last[i]} !== {wr_data[i], 2'b00, i == 3}) begin
                n_fail++; $display("FAIL basic_beat%0d got=%h/%b/%b exp=%h/00/%b",
                    i, rd_data[i], rd_resp[i], rd_last[i], wr_data[i], i == 3);
            end
        end
        n_cmp++;
        if (r_valid !== 1'b0) begin n_fail++; $display("FAIL basic_rvalid_drop got=%b exp=0", r_valid); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 8; i++) wr_data[i] = 32'hA000_0000 + 32'(i) * 32'h0101;
        do_write(32'h80, 8'd7, 3'd2, 2'b01, 4'hF, -1);
        do_read(32'h80, 8'd7, 3'd2, 2'b01, 1'b1);
        n_cmp++;
        if (rd_n !== 8) begin n_fail++; $display("FAIL stall_beats got=%0d exp=8", rd_n); end
        n_cmp++;
        if (unstable_n !== 0) begin n_fail++; $display("FAIL stall_stable got=%0d exp=0", unstable_n); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (rd_data[i] !== wr_data[i]) begin
                n_fail++; $display("FAIL stall_beat%0d got=%h exp=%h", i, rd_data[i], wr_data[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_incr [4];
        for (int i = 0; i < 4; i++) wr_data[i] = 32'hB0B0_0000 + 32'(i);
        exp_incr[0] = wr_data[2]; exp_incr[1] = wr_data[3];
        exp_incr[2] = wr_data[0]; exp_incr[3] = wr_data[1];
        do_write(32'h38, 8'd3, 3'd2, 2'b10, 4'hF, -1);
        n_cmp++;
        if (got_bresp !== 2'b00) begin n_fail++; $display("FAIL wrap_bresp got=%b exp=00", got_bresp); end
        do_read(32'h30, 8'd3, 3'd2, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd_data[i] !== exp_incr[i]) begin
                n_fail++; $display("FAIL wrap_layout%0d got=%h exp=%h", i, rd_data[i], exp_incr[i]);
            end
        end
        do_read(32'h38, 8'd3, 3'd2, 2'b10, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd_data[i] !== wr_data[i]) begin
                n_fail++; $display("FAIL wrap_read%0d got=%h exp=%h", i, rd_data[i], wr_data[i]);
            end
        end
    endtask

    task automatic test_narrow();
        wr_data[0] = 32'h4433_2211;
        do_write(32'h100, 8'd0, 3'd2, 2'b01, 4'hF, -1);
        wr_data[0] = 32'h0000_AB00;
        do_write(32'h101, 8'd0, 3'd0, 2'b00, 4'b0010, -1);
        n_cmp++;
        if (got_bresp !== 2'b00) begin n_fail++; $display("FAIL narrow_bresp got=%b exp=00", got_bresp); end
        do_read(32'h100, 8'd0, 3'd2, 2'b01, 1'b0);
        n_cmp++;
        if (rd_data[0] !== 32'h4433_AB11) begin
            n_fail++; $display("FAIL narrow_word got=%h exp=4433ab11", rd_data[0]);
        end
    endtask

    task automatic test_out_of_range();
        wr_data[0] = 32'hCAFE_F00D;
        do_write(32'h0, 8'd0, 3'd2, 2'b01, 4'hF, -1);
        wr_data[0] = 32'h1111_1111; wr_data[1] = 32'h2222_2222;
        do_write(32'h1000, 8'd1, 3'd2, 2'b01, 4'hF, -1);
        n_cmp++;
        if (got_bresp !== 2'b10) begin n_fail++; $display("FAIL oob_bresp got=%b exp=10", got_bresp); end
        do_read(32'h1000, 8'd1, 3'd2, 2'b01, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({rd_data[i], rd_resp[i]} !== {32'h0, 2'b10}) begin
                n_fail++; $display("FAIL oob_read%0d got=%h/%b exp=0/10", i, rd_data[i], rd_resp[i]);
            end
        end
        do_read(32'h0, 8'd0, 3'd2, 2'b01, 1'b0);
        n_cmp++;
        if (rd_data[0] !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL oob_ram_intact got=%h exp=cafef00d", rd_data[0]);
        end
    endtask

    task automatic test_errors();
        wr_data[0] = 32'h5; wr_data[1] = 32'h6; wr_data[2] = 32'h7;
        do_write(32'h300, 8'd0, 3'd2, 2'b11, 4'hF, -1);
        n_cmp++;
        if (got_bresp !== 2'b10) begin n_fail++; $display("FAIL err_burst11 got=%b exp=10", got_bresp); end
        do_write(32'h300, 8'd1, 3'd2, 2'b01, 4'hF, 0);
        n_cmp++;
        if (got_bresp !== 2'b10) begin n_fail++; $display("FAIL err_wlast got=%b exp=10", got_bresp); end
        do_write(32'h300, 8'd2, 3'd2, 2'b10, 4'hF, -1);
        n_cmp++;
        if (got_bresp !== 2'b10) begin n_fail++; $display("FAIL err_wraplen got=%b exp=10", got_bresp); end
        do_write(32'h300, 8'd0, 3'd3, 2'b01, 4'hF, -1);
        n_cmp++;
        if (got_bresp !== 2'b10) begin n_fail++; $display("FAIL err_size got=%b exp=10", got_bresp); end
        do_write(32'h300, 8'd1, 3'd2, 2'b01, 4'hF, -1);
        n_cmp++;
        if (got_bresp !== 2'b00) begin n_fail++; $display("FAIL err_recover got=%b exp=00", got_bresp); end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] exp_w [4];
        for (int i = 0; i < 4; i++) wr_data[i] = 32'h9000_0000 + 32'(i);
        do_write(32'h200, 8'd3, 3'd2, 2'b01, 4'hF, -1);
        exp_w[0] = 32'h7700_0000; exp_w[1] = 32'h7700_0001; exp_w[2] = wr_data[2]; exp_w[3] = wr_data[3];
        aw_addr = 32'h200; aw_len = 8'd3; aw_size = 3'd2; aw_burst = 2'b01; aw_valid = 1'b1;
        tick();
        aw_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            w_data = 32'h7700_0000 + 32'(i); w_strb = 4'hF; w_last = 1'b0; w_valid = 1'b1;
            tick();
        end
        w_data = 32'h7700_0002;
        areset_n = 1'b0;
        tick();
        n_cmp++;
        if ({aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp, r_last} !== 42'd0) begin
            n_fail++; $display("FAIL midrst_outputs got=%h exp=0",
                {aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp, r_last});
        end
        w_valid = 1'b0;
        areset_n = 1'b1;
        tick();
        do_read(32'h200, 8'd3, 3'd2, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd_data[i] !== exp_w[i]) begin
                n_fail++; $display("FAIL midrst_ram%0d got=%h exp=%h", i, rd_data[i], exp_w[i]);
            end
        end
        wr_data[0] = 32'h1234_5678; wr_data[1] = 32'h8765_4321;
        do_write(32'h200, 8'd1, 3'd2, 2'b01, 4'hF, -1);
        n_cmp++;
        if (got_bresp !== 2'b00) begin n_fail++; $display("FAIL midrst_newburst got=%b exp=00", got_bresp); end
        do_read(32'h200, 8'd1, 3'd2, 2'b01, 1'b0);
        n_cmp++;
        if ({rd_data[0], rd_data[1]} !== {32'h1234_5678, 32'h8765_4321}) begin
            n_fail++; $display("FAIL midrst_readback got=%h %h exp=12345678 87654321", rd_data[0], rd_data[1]);
        end
    endtask

    initial begin
        aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0; aw_cache = '0; aw_valid = 1'b0;
        w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
        ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0; ar_cache = '0; ar_valid = 1'b0;
        r_ready = 1'b0; areset_n = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_narrow();
        test_out_of_range();
        test_errors();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
